// File: rtl/shift_seq_if.sv
// shift_seq_if: request and result signals between a shift_seq client and the shifter.
interface shift_seq_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 6
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [SHW-1:0]   B;
    logic [1:0]       op;
    logic [WIDTH-1:0] C;
    logic             busy;
    logic             done;
    modport master (output start, A, B, op, input C, busy, done);
    modport slave (input start, A, B, op, output C, busy, done);
endinterface

// File: rtl/shift_seq.sv
// shift_seq: sequential shifter, one bit per cycle, left / logical right / arithmetic right.
module shift_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 6
) (
    input logic       clock,
    input logic       reset,
    shift_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] work, work_n, c_q, c_n;
    logic [SHW-1:0]   cnt, cnt_n;
    logic [1:0]       op_q, op_n;
    logic             accept;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            work  <= '0;
            c_q   <= '0;
            cnt   <= '0;
            op_q  <= '0;
        end else begin
            state <= state_n;
            work  <= work_n;
            c_q   <= c_n;
            cnt   <= cnt_n;
            op_q  <= op_n;
        end
    end
    // The edge leaving DONE also accepts a held start, giving n+2 cycle throughput.
    assign accept = (state != SHIFT) && bus.start;
    always_comb begin
        state_n = state;
        work_n  = work;
        c_n     = c_q;
        cnt_n   = cnt;
        op_n    = op_q;
        if (accept) begin
            state_n = SHIFT;
            work_n  = bus.A;
            op_n    = bus.op;
            cnt_n   = (bus.B > SHW'(WIDTH)) ? SHW'(WIDTH) : bus.B;
        end else if (state == DONE) begin
            state_n = IDLE;
        end else if (state == SHIFT && cnt != '0) begin
            work_n = (op_q == 2'b00) ? {work[WIDTH-2:0], 1'b0}
                   : {(op_q == 2'b10) ? work[WIDTH-1] : 1'b0, work[WIDTH-1:1]};
            cnt_n  = cnt - 1'b1;
        end else if (state == SHIFT) begin
            c_n     = work;
            state_n = DONE;
        end
    end
    assign bus.C    = c_q;
    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: directed checks of shift_seq results, latency, hold, abort and throughput.
module tb_shift_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    shift_seq_if #(.WIDTH(32), .SHW(6)) bus ();
    shift_seq #(.WIDTH(32), .SHW(6)) dut (.clock(clk), .reset(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [5:0] b,
                          input logic [1:0] o, input logic [31:0] exp, input int lat, input bit disturb);
        int          cyc;
        logic        moved;
        logic [31:0] c0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.op    = o;
        @(negedge clk);
        c0        = bus.C;
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.B     = b + 6'd7;
        bus.op    = ~o;
        check($sformatf("%s busy", tag), 64'(bus.busy), 64'd1);
        cyc   = 0;
        moved = 1'b0;
        while (!bus.done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (!bus.done && bus.C !== c0) moved = 1'b1;
            bus.start = disturb && cyc == 3;
            if (disturb && cyc == 3) bus.A = 32'hFFFF_FFFF;
        end
        check($sformatf("%s C", tag), 64'(bus.C), 64'(exp));
        check($sformatf("%s latency", tag), 64'(cyc), 64'(lat));
        check($sformatf("%s C hold", tag), 64'(moved), 64'd0);
        check($sformatf("%s busy in done", tag), 64'(bus.busy), 64'd0);
        @(negedge clk);
        check($sformatf("%s done width", tag), 64'(bus.done), 64'd0);
    endtask

    logic [31:0] va [10] = '{32'h1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF,
                            32'hDEAD_BEEF, 32'h8000_0000, 32'hDEAD_BEEF, 32'h7FFF_FFFF, 32'h0000_F000};
    logic [5:0]  vb [10] = '{6'd3, 6'd3, 6'd3, 6'd3, 6'd0, 6'd40, 6'd63, 6'd32, 6'd63, 6'd4};
    logic [1:0]  vo [10] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01};
    logic [31:0] ve [10] = '{32'h8, 32'hF000_0000, 32'h1000_0000, 32'h1000_0000, 32'hDEAD_BEEF,
                            32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0000_0F00};
    int          vl [10] = '{4, 4, 4, 4, 1, 33, 33, 33, 33, 5};
    logic [31:0] tav [3] = '{32'h1, 32'h3, 32'h1000_0000};
    logic [31:0] tev [3] = '{32'h4, 32'hC, 32'h4000_0000};

    initial begin
        bit seen;
        int idx;
        bus.start = 1'b1;
        bus.A     = 32'h1234_5678;
        bus.B     = 6'd5;
        bus.op    = 2'b00;
        repeat (3) @(negedge clk);
        check("reset C", 64'(bus.C), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        bus.start = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        check("idle busy", 64'(bus.busy), 64'd0);
        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), va[i], vb[i], vo[i], ve[i], vl[i], 1'b0);
        run_op("restart", 32'h55, 6'd10, 2'b00, 32'h0001_5400, 11, 1'b1);

        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 32'h1234;
        bus.B     = 6'd20;
        bus.op    = 2'b00;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort C", 64'(bus.C), 64'd0);
        check("abort busy", 64'(bus.busy), 64'd0);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        check("abort no done", 64'(seen), 64'd0);
        run_op("after abort", 32'h1, 6'd1, 2'b00, 32'h2, 2, 1'b0);

        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = tav[0];
        bus.B     = 6'd2;
        bus.op    = 2'b00;
        idx       = 0;
        for (int c = 0; c < 20 && idx < 3; c++) begin
            @(negedge clk);
            if (bus.done) begin
                check($sformatf("b2b%0d C", idx), 64'(bus.C), 64'(tev[idx]));
                check($sformatf("b2b%0d cycle", idx), 64'(c), 64'(3 + 4 * idx));
                idx++;
                if (idx < 3) bus.A = tav[idx];
                else bus.start = 1'b0;
            end
        end
        check("b2b count", 64'(idx), 64'd3);
        repeat (2) @(negedge clk);
        check("b2b idle", 64'(bus.busy), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
